// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through data cache with one 32-bit word per line.
// Loads allocate on miss; stores go through to memory and merge into the line only on a hit.
module dcache_wt #(
    parameter int unsigned INDEX_BITS = 7
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    input  logic        flush,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_len,
    input  logic        mem_done,
    input  logic [31:0] mem_rdata
);
    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = 30 - INDEX_BITS;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_MISS = 2'd1;
    localparam logic [1:0] S_WR_THRU = 2'd2;
    localparam logic [1:0] S_FLUSH   = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [31:0]           data_mem [LINES];
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [LINES-1:0]      valid;

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [1:0]            req_off;
    logic                  hit;
    logic                  misaligned;
    logic                  accept;
    logic                  flush_go;
    logic                  done;

    logic [INDEX_BITS-1:0] lat_idx;
    logic [TAG_W-1:0]      lat_tag;
    logic [1:0]            lat_off;
    logic [1:0]            lat_size;
    logic                  lat_signed;
    logic                  lat_hit;
    logic [31:0]           lat_wdata;

    // Lane select and zero/sign extension of a load from a full word.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [1:0] size, input logic sgn);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        if (size == 2'd0) begin
            res = {{24{sgn & sh[7]}}, sh[7:0]};
        end else if (size == 2'd1) begin
            if (off[1]) res = {{16{sgn & word[31]}}, word[31:16]};
            else        res = {{16{sgn & word[15]}}, word[15:0]};
        end else begin
            res = word;
        end
        return res;
    endfunction

    // Merge size-masked store data into the bytes it covers.
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [1:0] off, input logic [1:0] size);
        logic [31:0] mask;
        case (size)
            2'd0:    mask = 32'h0000_00FF;
            2'd1:    mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        mask = mask << {off, 3'b000};
        return (old & ~mask) | ((wdata << {off, 3'b000}) & mask);
    endfunction

    function automatic logic [2:0] size_len(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    assign req_idx   = req_addr[INDEX_BITS+1:2];
    assign req_tag   = req_addr[31:INDEX_BITS+2];
    assign req_off   = req_addr[1:0];
    assign req_ready = (state == S_IDLE) && !rst_in;
    assign accept    = req_valid && req_ready && rdy;
    assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign flush_go  = rdy && !rst_in && (state == S_IDLE) && flush && !req_valid;
    assign done      = rdy && !rst_in && mem_done && ((state == S_RD_MISS) || (state == S_WR_THRU));

    // Alignment check of the incoming request.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd1:    misaligned = req_off[0];
            2'd2:    misaligned = (req_off != 2'd0);
            2'd3:    misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    // Next-state decode; everything holds while rdy is low.
    always_comb begin
        state_next = state;
        if (rdy) begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (!misaligned && req_write)  state_next = S_WR_THRU;
                        else if (!misaligned && !hit)  state_next = S_RD_MISS;
                    end else if (flush_go) begin
                        state_next = S_FLUSH;
                    end
                end
                S_RD_MISS, S_WR_THRU: if (mem_done) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= S_IDLE;
        else        state <= state_next;
    end

    // Valid bits, response and memory-port registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid      <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_len    <= 3'd0;
        end else if (rdy) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            if (accept) begin
                if (misaligned) begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b1;
                end else if (req_write) begin
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_addr  <= req_addr;
                    mem_wdata <= req_wdata;
                    mem_len   <= size_len(req_size);
                end else if (hit) begin
                    resp_valid <= 1'b1;
                    resp_rdata <= load_extract(data_mem[req_idx], req_off, req_size, req_signed);
                end else begin
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= {req_addr[31:2], 2'b00};
                    mem_len  <= 3'd4;
                end
            end
            if (flush_go) valid <= '0;
            if (done) begin
                mem_req    <= 1'b0;
                resp_valid <= 1'b1;
                if (state == S_RD_MISS) begin
                    valid[lat_idx] <= 1'b1;
                    resp_rdata     <= load_extract(mem_rdata, lat_off, lat_size, lat_signed);
                end
            end
        end
    end

    // Request latch and data/tag arrays (not reset).
    always_ff @(posedge clk_in) begin
        if (accept) begin
            lat_idx    <= req_idx;
            lat_tag    <= req_tag;
            lat_off    <= req_off;
            lat_size   <= req_size;
            lat_signed <= req_signed;
            lat_hit    <= hit;
            lat_wdata  <= req_wdata;
        end
        if (done && (state == S_RD_MISS)) begin
            data_mem[lat_idx] <= mem_rdata;
            tag_mem[lat_idx]  <= lat_tag;
        end
        if (done && (state == S_WR_THRU) && lat_hit) begin
            data_mem[lat_idx] <= store_merge(data_mem[lat_idx], lat_wdata, lat_off, lat_size);
        end
    end
endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: directed scenarios plus randomized traffic checked against a
// word-level memory model and a per-index residency table.
module tb_dcache_wt;
    localparam int unsigned INDEX_BITS = 7;
    localparam int unsigned LINES = 1 << INDEX_BITS;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy, req_valid, req_write, req_signed, flush, mem_done;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, mem_rdata;
    logic        req_ready, resp_valid, resp_err, mem_req, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [2:0]  mem_len;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] resident  [LINES];
    logic        res_ok    [LINES];

    logic        ob_mem, ob_we, ob_held, ob_rv, ob_err, ob_rdy;
    logic [31:0] ob_addr, ob_wdata, ob_rdata;
    logic [2:0]  ob_len;

    dcache_wt #(.INDEX_BITS(INDEX_BITS)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy(rdy),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .flush(flush),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_len(mem_len),
        .mem_done(mem_done), .mem_rdata(mem_rdata)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_word(input logic [31:0] waddr);
        if (mem_model.exists(waddr)) return mem_model[waddr];
        return (waddr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] w;
        int unsigned n;
        int unsigned pos;
        w = model_word(a >> 2);
        n = 1 << sz;
        for (int b = 0; b < int'(n); b++) begin
            pos = (a % 4) + b;
            w[8*pos +: 8] = wd[8*b +: 8];
        end
        mem_model[a >> 2] = w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [31:0] a,
                                             input logic [1:0] sz, input logic sg);
        logic [31:0] v;
        int unsigned off;
        off = a % 4;
        if (sz == 2'd2) return word;
        if (sz == 2'd0) begin
            v = (word >> (8 * off)) & 32'hFF;
            if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else begin
            v = (word >> (8 * off)) & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic void clear_resident();
        for (int i = 0; i < int'(LINES); i++) res_ok[i] = 1'b0;
    endfunction

    // Drive one request and play the memory controller; results land in ob_*.
    task automatic issue_op(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd_word, input int lat);
        @(negedge clk_in);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        @(posedge clk_in); #1;
        ob_mem = mem_req; ob_we = mem_we; ob_addr = mem_addr; ob_len = mem_len; ob_wdata = mem_wdata;
        ob_rv = resp_valid; ob_err = resp_err; ob_rdata = resp_rdata; ob_rdy = req_ready; ob_held = 1'b1;
        @(negedge clk_in);
        req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        if (ob_mem) begin
            for (int k = 1; k < lat; k++) begin
                @(posedge clk_in); #1;
                if (!(mem_req === 1'b1 && mem_addr === ob_addr && mem_len === ob_len &&
                      mem_we === ob_we && mem_wdata === ob_wdata && resp_valid === 1'b0)) ob_held = 1'b0;
                @(negedge clk_in);
            end
            mem_done = 1'b1; mem_rdata = rd_word;
            @(posedge clk_in); #1;
            if (mem_req !== 1'b0) ob_held = 1'b0;
            ob_rv = resp_valid; ob_err = resp_err; ob_rdata = resp_rdata;
            @(negedge clk_in);
            mem_done = 1'b0; mem_rdata = $urandom;
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; flush = 1'b0;
        mem_done = 1'b0; mem_rdata = 32'd0;
        clear_resident();
        repeat (3) @(posedge clk_in);
        #1;
        tests++;
        if ({resp_valid, resp_err, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_len} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: rv=%b err=%b rdata=%h req=%b we=%b addr=%h wdata=%h len=%0d, expected all 0",
                     resp_valid, resp_err, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_len);
        end
        tests++;
        if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_low: got %b expected 0", req_ready); end
        @(negedge clk_in); rst_in = 1'b0; #1;
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL idle_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_load_miss_hit();
        mem_model[32'h100 >> 2] = 32'h8899_AABB;
        issue_op(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, model_word(32'h40), 3);
        tests++;
        if ({ob_mem, ob_we, ob_addr, ob_len, ob_rdy} !== {1'b1, 1'b0, 32'h100, 3'd4, 1'b0}) begin
            fails++;
            $display("FAIL lw_miss_req: got req=%b we=%b addr=%h len=%0d ready=%b, expected 1 0 00000100 4 0",
                     ob_mem, ob_we, ob_addr, ob_len, ob_rdy);
        end
        tests++;
        if (ob_held !== 1'b1) begin fails++; $display("FAIL lw_miss_hold: mem_req not held stable for 3 cycles"); end
        tests++;
        if ({ob_rv, ob_err, ob_rdata} !== {1'b1, 1'b0, 32'h8899_AABB}) begin
            fails++; $display("FAIL lw_miss_resp: got rv=%b err=%b rdata=%h expected 1 0 8899aabb", ob_rv, ob_err, ob_rdata);
        end
        resident[32'h40] = 32'h40; res_ok[32'h40] = 1'b1;
        issue_op(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 32'hDEAD_BEEF, 3);
        tests++;
        if ({ob_mem, ob_rv, ob_rdy, ob_rdata} !== {1'b0, 1'b1, 1'b1, 32'h8899_AABB}) begin
            fails++;
            $display("FAIL lw_hit: got req=%b rv=%b ready=%b rdata=%h expected 0 1 1 8899aabb", ob_mem, ob_rv, ob_rdy, ob_rdata);
        end
    endtask

    task automatic test_lane_select();
        logic [1:0]  sz [4]  = '{2'd0, 2'd0, 2'd1, 2'd1};
        logic        sg [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ad [4]  = '{32'h103, 32'h103, 32'h102, 32'h100};
        logic [31:0] ex [4]  = '{32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_8899, 32'h0000_AABB};
        for (int i = 0; i < 4; i++) begin
            issue_op(1'b0, sz[i], sg[i], ad[i], 32'd0, 32'hDEAD_BEEF, 2);
            tests++;
            if ({ob_mem, ob_rv, ob_rdata} !== {1'b0, 1'b1, ex[i]}) begin
                fails++;
                $display("FAIL lane_%0d: got req=%b rv=%b rdata=%h expected 0 1 %h", i, ob_mem, ob_rv, ob_rdata, ex[i]);
            end
        end
    endtask

    task automatic test_store();
        issue_op(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_1234, 32'hDEAD_BEEF, 2);
        tests++;
        if ({ob_mem, ob_we, ob_addr, ob_len, ob_wdata[15:0], ob_held} !== {1'b1, 1'b1, 32'h102, 3'd2, 16'h1234, 1'b1}) begin
            fails++;
            $display("FAIL sh_req: got req=%b we=%b addr=%h len=%0d wdata=%h held=%b expected 1 1 00000102 2 1234 1",
                     ob_mem, ob_we, ob_addr, ob_len, ob_wdata, ob_held);
        end
        tests++;
        if ({ob_rv, ob_err, ob_rdata} !== {1'b1, 1'b0, 32'd0}) begin
            fails++; $display("FAIL sh_resp: got rv=%b err=%b rdata=%h expected 1 0 0", ob_rv, ob_err, ob_rdata);
        end
        model_store(32'h102, 2'd1, 32'h0000_1234);
        issue_op(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 32'hDEAD_BEEF, 2);
        tests++;
        if ({ob_mem, ob_rdata} !== {1'b0, 32'h1234_AABB}) begin
            fails++; $display("FAIL sh_merge: got req=%b rdata=%h expected 0 1234aabb", ob_mem, ob_rdata);
        end
        issue_op(1'b1, 2'd0, 1'b0, 32'h504, 32'hCAFE_0077, 32'hDEAD_BEEF, 1);
        tests++;
        if ({ob_mem, ob_we, ob_addr, ob_len} !== {1'b1, 1'b1, 32'h504, 3'd1}) begin
            fails++; $display("FAIL sb_req: got req=%b we=%b addr=%h len=%0d expected 1 1 00000504 1", ob_mem, ob_we, ob_addr, ob_len);
        end
        model_store(32'h504, 2'd0, 32'hCAFE_0077);
        issue_op(1'b0, 2'd2, 1'b0, 32'h504, 32'd0, model_word(32'h504 >> 2), 2);
        tests++;
        if ({ob_mem, ob_rdata} !== {1'b1, model_word(32'h504 >> 2)}) begin
            fails++; $display("FAIL sb_no_alloc: got req=%b rdata=%h expected 1 %h", ob_mem, ob_rdata, model_word(32'h504 >> 2));
        end
        resident[32'h41] = 32'h141; res_ok[32'h41] = 1'b1;
    endtask

    task automatic test_misaligned();
        logic [1:0]  sz [3] = '{2'd1, 2'd2, 2'd3};
        logic [31:0] ad [3] = '{32'h101, 32'h102, 32'h100};
        for (int i = 0; i < 3; i++) begin
            issue_op(1'(i == 2), sz[i], 1'b1, ad[i], 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1);
            tests++;
            if ({ob_mem, ob_rv, ob_err, ob_rdata, ob_rdy} !== {1'b0, 1'b1, 1'b1, 32'd0, 1'b1}) begin
                fails++;
                $display("FAIL misaligned_%0d: got req=%b rv=%b err=%b rdata=%h ready=%b expected 0 1 1 0 1",
                         i, ob_mem, ob_rv, ob_err, ob_rdata, ob_rdy);
            end
        end
    endtask

    task automatic test_conflict();
        logic [31:0] far_a;
        far_a = 32'h100 + (32'd4 << INDEX_BITS);
        issue_op(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 32'hDEAD_BEEF, 1);
        tests++;
        if ({ob_mem, ob_rdata} !== {1'b0, 32'h1234_AABB}) begin
            fails++; $display("FAIL conflict_pre_hit: got req=%b rdata=%h expected 0 1234aabb", ob_mem, ob_rdata);
        end
        issue_op(1'b0, 2'd2, 1'b0, far_a, 32'd0, model_word(far_a >> 2), 2);
        tests++;
        if ({ob_mem, ob_addr, ob_rdata} !== {1'b1, far_a, model_word(far_a >> 2)}) begin
            fails++; $display("FAIL conflict_evict: got req=%b addr=%h rdata=%h expected 1 %h %h",
                              ob_mem, ob_addr, ob_rdata, far_a, model_word(far_a >> 2));
        end
        issue_op(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, model_word(32'h40), 2);
        tests++;
        if ({ob_mem, ob_rdata} !== {1'b1, 32'h1234_AABB}) begin
            fails++; $display("FAIL conflict_refill: got req=%b rdata=%h expected 1 1234aabb", ob_mem, ob_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  sz [3] = '{2'd2, 2'd0, 2'd1};
        logic [31:0] ad [3] = '{32'h100, 32'h100, 32'h102};
        logic [31:0] ex [3] = '{32'h1234_AABB, 32'h0000_00BB, 32'h0000_1234};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            req_valid = 1'b1; req_write = 1'b0; req_size = sz[i]; req_signed = 1'b0; req_addr = ad[i];
            @(posedge clk_in); #1;
            tests++;
            if ({resp_valid, resp_rdata, req_ready, mem_req} !== {1'b1, ex[i], 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL b2b_%0d: got rv=%b rdata=%h ready=%b req=%b expected 1 %h 1 0",
                         i, resp_valid, resp_rdata, req_ready, mem_req, ex[i]);
            end
        end
        @(negedge clk_in); req_valid = 1'b0;
        @(posedge clk_in); #1;
        tests++;
        if (resp_valid !== 1'b0) begin fails++; $display("FAIL b2b_pulse_end: got rv=%b expected 0", resp_valid); end
    endtask

    task automatic test_rdy_stall();
        logic [31:0] w;
        logic        ok;
        w = model_word(32'h400 >> 2);
        @(negedge clk_in);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h400;
        @(posedge clk_in); #1;
        @(negedge clk_in); req_valid = 1'b0; rdy = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mem_done = (k == 2); mem_rdata = 32'h0BAD_0BAD;
            @(posedge clk_in); #1;
            if (!(mem_req === 1'b1 && mem_addr === 32'h400 && mem_len === 3'd4 && resp_valid === 1'b0)) ok = 1'b0;
            @(negedge clk_in);
        end
        tests++;
        if (ok !== 1'b1) begin fails++; $display("FAIL rdy_hold: outputs changed while rdy low (req=%b addr=%h)", mem_req, mem_addr); end
        mem_done = 1'b0; rdy = 1'b1;
        @(posedge clk_in); #1;
        tests++;
        if ({mem_req, resp_valid} !== 2'b10) begin
            fails++; $display("FAIL rdy_done_lost: got req=%b rv=%b expected 1 0", mem_req, resp_valid);
        end
        @(negedge clk_in); mem_done = 1'b1; mem_rdata = w;
        @(posedge clk_in); #1;
        tests++;
        if ({mem_req, resp_valid, resp_rdata} !== {1'b0, 1'b1, w}) begin
            fails++; $display("FAIL rdy_resume: got req=%b rv=%b rdata=%h expected 0 1 %h", mem_req, resp_valid, resp_rdata, w);
        end
        @(negedge clk_in); mem_done = 1'b0;
    endtask

    task automatic test_flush();
        @(negedge clk_in);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h100; flush = 1'b1;
        @(posedge clk_in); #1;
        tests++;
        if ({resp_valid, mem_req, resp_rdata} !== {1'b1, 1'b0, 32'h1234_AABB}) begin
            fails++; $display("FAIL flush_vs_req: got rv=%b req=%b rdata=%h expected 1 0 1234aabb", resp_valid, mem_req, resp_rdata);
        end
        @(negedge clk_in); req_valid = 1'b0;
        @(posedge clk_in); #1;
        tests++;
        if (req_ready !== 1'b0) begin fails++; $display("FAIL flush_state: got ready=%b expected 0", req_ready); end
        @(negedge clk_in); flush = 1'b0; mem_done = 1'b1;
        @(posedge clk_in); #1;
        tests++;
        if ({req_ready, resp_valid, mem_req} !== 3'b100) begin
            fails++; $display("FAIL flush_exit: got ready=%b rv=%b req=%b expected 1 0 0", req_ready, resp_valid, mem_req);
        end
        @(negedge clk_in); mem_done = 1'b0;
        clear_resident();
        issue_op(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, model_word(32'h40), 1);
        tests++;
        if ({ob_mem, ob_rdata} !== {1'b1, 32'h1234_AABB}) begin
            fails++; $display("FAIL flush_miss: got req=%b rdata=%h expected 1 1234aabb", ob_mem, ob_rdata);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_in);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h100; req_wdata = $urandom;
        @(posedge clk_in); #1;
        tests++;
        if ({mem_req, mem_we} !== 2'b11) begin fails++; $display("FAIL rstmid_start: got req=%b we=%b expected 1 1", mem_req, mem_we); end
        @(negedge clk_in); req_valid = 1'b0; rst_in = 1'b1;
        @(posedge clk_in); #1;
        tests++;
        if ({mem_req, resp_valid, req_ready} !== 3'b000) begin
            fails++; $display("FAIL rstmid_abort: got req=%b rv=%b ready=%b expected 0 0 0", mem_req, resp_valid, req_ready);
        end
        @(negedge clk_in); rst_in = 1'b0; mem_done = 1'b1;
        @(posedge clk_in); #1;
        tests++;
        if ({mem_req, resp_valid} !== 2'b00) begin
            fails++; $display("FAIL rstmid_stray_done: got req=%b rv=%b expected 0 0", mem_req, resp_valid);
        end
        @(negedge clk_in); mem_done = 1'b0;
        clear_resident();
        issue_op(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, model_word(32'h40), 2);
        tests++;
        if ({ob_mem, ob_rdata} !== {1'b1, model_word(32'h40)}) begin
            fails++; $display("FAIL rstmid_invalid: got req=%b rdata=%h expected 1 %h", ob_mem, ob_rdata, model_word(32'h40));
        end
        resident[32'h40] = 32'h40; res_ok[32'h40] = 1'b1;
    endtask

    task automatic test_random();
        logic        wr, sg, mis, hit, exp_mem;
        logic [1:0]  sz;
        logic [31:0] a, wd, waddr, exp_data, idx;
        for (int n = 0; n < 300; n++) begin
            wr = ($urandom_range(0, 9) < 4);
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            sg = 1'($urandom);
            a  = 32'h0001_0000 + (32'($urandom_range(0, 2)) << (INDEX_BITS + 2))
                 + (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3));
            wd = $urandom;
            waddr = a >> 2;
            idx   = waddr % LINES;
            mis   = is_misaligned(sz, a);
            hit   = res_ok[idx] && (resident[idx] == waddr);
            exp_mem  = !mis && (wr || !hit);
            exp_data = (mis || wr) ? 32'd0 : exp_load(model_word(waddr), a, sz, sg);
            issue_op(wr, sz, sg, a, wd, model_word(waddr), $urandom_range(1, 4));
            tests++;
            if ({ob_rv, ob_err, ob_rdata, ob_mem} !== {1'b1, mis, exp_data, exp_mem}) begin
                fails++;
                $display("FAIL rnd_%0d_resp: a=%h sz=%0d wr=%b got rv=%b err=%b rdata=%h req=%b expected 1 %b %h %b",
                         n, a, sz, wr, ob_rv, ob_err, ob_rdata, ob_mem, mis, exp_data, exp_mem);
            end
            if (exp_mem) begin
                tests++;
                if (wr ? ({ob_we, ob_addr, ob_len, ob_wdata, ob_held} !== {1'b1, a, 3'(1 << sz), wd, 1'b1})
                       : ({ob_we, ob_addr, ob_len, ob_held} !== {1'b0, waddr << 2, 3'd4, 1'b1})) begin
                    fails++;
                    $display("FAIL rnd_%0d_mem: a=%h wr=%b got we=%b addr=%h len=%0d wdata=%h held=%b",
                             n, a, wr, ob_we, ob_addr, ob_len, ob_wdata, ob_held);
                end
                if (wr) model_store(a, sz, wd);
                else begin resident[idx] = waddr; res_ok[idx] = 1'b1; end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_miss_hit();
        test_lane_select();
        test_store();
        test_misaligned();
        test_conflict();
        test_back_to_back();
        test_rdy_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
